// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus downstream valid/ready stream of the burst reader.
// The master side is the reader, and the slave side is the FIFO and the consumer.
interface fifo_burst_reader_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
);
   logic              fifo_rd_en;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;

   modport master (
      output fifo_rd_en,
      input  fifo_dout, fifo_empty, fifo_count,
      output m_data, m_valid, m_last,
      input  m_ready
   );

   modport slave (
      input  fifo_rd_en,
      output fifo_dout, fifo_empty, fifo_count,
      input  m_data, m_valid, m_last,
      output m_ready
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst read controller: pops FIFO bytes in bursts of up to BURST_LEN and streams them out.
// A 3-entry skid buffer absorbs the FIFO's one-cycle read latency, and its head drives the stream.
module fifo_burst_reader #(
   parameter int DATA_W    = 8,
   parameter int CNT_W     = 8,
   parameter int BURST_LEN = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   fifo_burst_reader_if.master bus,
   output logic [15:0]         bursts_done
);
   localparam int BL_W  = $clog2(BURST_LEN + 1);
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, DRAIN} state_e;

   state_e            state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [BL_W-1:0]   blen_q, blen_d;
   logic [BL_W-1:0]   issued_q, issued_d;
   logic [BL_W-1:0]   sent_q, sent_d;
   logic [1:0]        occ_q, occ_d;
   logic              inflight_q, inflight_d;
   logic [DATA_W-1:0] buf_q [3];
   logic [DATA_W-1:0] buf_d [3];
   logic [15:0]       bursts_q, bursts_d;

   logic rd_en;
   logic xfer;
   logic last_byte;
   logic full_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         blen_q     <= '0;
         issued_q   <= '0;
         sent_q     <= '0;
         occ_q      <= '0;
         inflight_q <= 1'b0;
         buf_q      <= '{default: '0};
         bursts_q   <= '0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         blen_q     <= blen_d;
         issued_q   <= issued_d;
         sent_q     <= sent_d;
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         buf_q      <= buf_d;
         bursts_q   <= bursts_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      blen_d     = blen_q;
      issued_d   = issued_q;
      sent_d     = sent_q;
      occ_d      = occ_q;
      buf_d      = buf_q;
      bursts_d   = bursts_q;
      rd_en      = 1'b0;
      xfer       = (occ_q != 2'd0) && bus.m_ready;
      last_byte  = (sent_q == blen_q - BL_W'(1));
      full_ready = (bus.fifo_count >= CNT_W'(BURST_LEN));

      unique case (state_q)
         IDLE: begin
            if (bus.fifo_count == '0 || full_ready) begin
               timer_d = '0;
            end else if (enable) begin
               timer_d = timer_q + TMR_W'(1);
            end
            if (enable && (full_ready ||
                (bus.fifo_count != '0 && timer_q == TMR_W'(TIMEOUT - 1)))) begin
               state_d  = DRAIN;
               blen_d   = full_ready ? BL_W'(BURST_LEN) : BL_W'(bus.fifo_count);
               issued_d = '0;
               sent_d   = '0;
               timer_d  = '0;
            end
         end
         DRAIN: begin
            // Reserve a skid slot for every byte held or still coming back from the FIFO.
            rd_en = (issued_q < blen_q) && !bus.fifo_empty &&
                    (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
            if (rd_en) begin
               issued_d = issued_q + BL_W'(1);
            end
            if (xfer) begin
               if (last_byte) begin
                  sent_d   = '0;
                  bursts_d = bursts_q + 16'd1;
                  state_d  = IDLE;
               end else begin
                  sent_d = sent_q + BL_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      inflight_d = rd_en;

      // Pop shifts the queue down first, so the returning byte lands just past the survivors.
      if (xfer) begin
         buf_d[0] = buf_q[1];
         buf_d[1] = buf_q[2];
         occ_d    = occ_q - 2'd1;
      end
      if (inflight_q) begin
         for (int unsigned i = 0; i < 3; i++) begin
            if (i == 32'(occ_d)) begin
               buf_d[i] = bus.fifo_dout;
            end
         end
         occ_d = occ_d + 2'd1;
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_data     = buf_q[0];
   assign bus.m_valid    = (occ_q != 2'd0);
   assign bus.m_last     = (state_q == DRAIN) && (occ_q != 2'd0) && last_byte;
   assign bursts_done    = bursts_q;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a behavioural FIFO feeds the reader, and a
// negedge monitor scores every stream transfer and every posted expectation.
module tb_fifo_burst_reader;
   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [15:0] bursts_done;

   fifo_burst_reader_if #(.DATA_W(8), .CNT_W(8)) bus ();

   fifo_burst_reader #(
      .DATA_W(8), .CNT_W(8), .BURST_LEN(4), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .bus(bus), .bursts_done(bursts_done)
   );

   always #5 clk = ~clk;

   // Written only by the stimulus process.
   logic [7:0] fq [$];
   logic [7:0] exp_data [$];
   bit         exp_last [$];
   string      req_name [$];
   int         req_act [$];
   int         req_exp [$];
   int         cyc = 0;
   int         rd_pulses = 0;
   bit         ready_mode = 1'b0;
   bit         acc;

   // Written only by the monitor process.
   int         n_checks = 0;
   int         n_fail = 0;
   int         mon_idx = 0;
   int         req_idx = 0;
   int         out_cnt = 0;
   bit         prev_stall = 1'b0;
   bit         prev_last;
   logic [7:0] prev_data;
   bit         m_xfer;

   task automatic chk(input string name, input int act, input int exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         out_cnt    = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            chk("stall_hold", int'({bus.m_valid, bus.m_last, bus.m_data}),
                int'({1'b1, prev_last, prev_data}));
         m_xfer = bus.m_valid && bus.m_ready;
         if (m_xfer) begin
            if (mon_idx < int'(exp_data.size())) begin
               chk("m_data", int'(bus.m_data), int'(exp_data[mon_idx]));
               chk("m_last", int'(bus.m_last), int'(exp_last[mon_idx]));
               mon_idx++;
            end else begin
               chk("unexpected_byte", int'(bus.m_data), -1);
            end
         end
         if (bus.fifo_rd_en && !bus.fifo_empty) begin
            chk("occ_plus_inflight_le3", int'(out_cnt + 1 <= 3), 1);
            out_cnt++;
         end
         if (m_xfer) out_cnt--;
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_data  = bus.m_data;
         prev_last  = bus.m_last;
      end
      while (req_idx < int'(req_act.size())) begin
         chk(req_name[req_idx], req_act[req_idx], req_exp[req_idx]);
         req_idx++;
      end
   end

   task automatic post(input string n, input int a, input int e);
      req_name.push_back(n);
      req_act.push_back(a);
      req_exp.push_back(e);
   endtask

   task automatic fifo_flags();
      bus.fifo_count = 8'(fq.size());
      bus.fifo_empty = (fq.size() == 0);
   endtask

   task automatic push(input logic [7:0] v, input bit expect_out, input bit last);
      fq.push_back(v);
      if (expect_out) begin
         exp_data.push_back(v);
         exp_last.push_back(last);
      end
      fifo_flags();
   endtask

   // One clock: a read accepted at the edge returns data and updated flags just after it.
   task automatic tick();
      @(negedge clk);
      acc = bus.fifo_rd_en && !bus.fifo_empty;
      @(posedge clk);
      #1;
      cyc++;
      if (acc && fq.size() > 0) begin
         bus.fifo_dout = fq.pop_front();
         rd_pulses++;
      end
      fifo_flags();
      bus.m_ready = ready_mode ? (cyc % 3 == 0) : 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      fq.delete();
      fifo_flags();
      ready_mode  = 1'b0;
      bus.m_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_rd(input int budget, output int n);
      n = 0;
      while (!bus.fifo_rd_en && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_bursts(input int target, input int budget);
      int n = 0;
      while (int'(bursts_done) != target && n < budget) begin
         tick();
         n++;
      end
      post("bursts_done", int'(bursts_done), target);
   endtask

   task automatic wait_data(input logic [7:0] v, input int budget);
      int n = 0;
      while (!(bus.m_valid && bus.m_data == v) && n < budget) begin
         tick();
         n++;
      end
      post("reach_byte", int'(bus.m_valid && bus.m_data == v), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int lat;
      int vcnt;
      rst            = 1'b1;
      enable         = 1'b1;
      bus.m_ready    = 1'b1;
      bus.fifo_dout  = '0;
      fifo_flags();

      // Reset held with five bytes waiting.
      for (int i = 1; i <= 5; i++) push(8'(i), 1'b1, (i >= 4));
      for (int i = 0; i < 2; i++) begin
         tick();
         post("reset_outputs", int'({bus.fifo_rd_en, bus.m_valid, bus.m_last, bus.m_data}), 0);
         post("reset_bursts", int'(bursts_done), 0);
      end
      rst = 1'b0;
      wait_rd(10, n);
      post("drain_after_reset", n, 1);
      wait_bursts(1, 30);
      wait_bursts(2, 60);

      // Full 4-byte burst at full rate.
      do_reset();
      push(8'd100, 1'b1, 1'b0);
      push(8'd150, 1'b1, 1'b0);
      push(8'd175, 1'b1, 1'b0);
      push(8'd200, 1'b1, 1'b1);
      wait_rd(10, n);
      rd_pulses = 0;
      lat = 0;
      while (!bus.m_valid && lat < 10) begin
         tick();
         lat++;
      end
      post("first_valid_latency", lat, 2);
      vcnt = 0;
      n = 0;
      while (bursts_done != 16'd1 && n < 20) begin
         if (bus.m_valid) vcnt++;
         tick();
         n++;
      end
      post("valid_cycles", vcnt, 4);
      post("rd_pulses", rd_pulses, 4);
      post("bursts_done", int'(bursts_done), 1);

      // Partial burst forced by the timeout.
      do_reset();
      push(8'd225, 1'b1, 1'b0);
      push(8'd250, 1'b1, 1'b1);
      wait_rd(40, n);
      post("timeout_wait", n, 16);
      wait_bursts(1, 20);

      // Two bursts under a stalling consumer.
      do_reset();
      ready_mode = 1'b1;
      for (int i = 0; i < 8; i++) push(8'(10 + i), 1'b1, (i == 3 || i == 7));
      wait_bursts(2, 200);
      ready_mode = 1'b0;

      // Enable dropped during byte 2 of a burst; bytes 34,35 drain later in the next burst.
      do_reset();
      for (int i = 0; i < 8; i++) push(8'(30 + i), (i < 6), (i == 3));
      wait_data(8'd31, 20);
      enable = 1'b0;
      wait_bursts(1, 30);
      rd_pulses = 0;
      repeat (30) tick();
      post("rd_while_disabled", rd_pulses, 0);
      post("bursts_hold", int'(bursts_done), 1);
      post("fifo_left", int'(bus.fifo_count), 4);

      // Reset pulsed while byte 3 of a burst is presented.
      enable = 1'b1;
      wait_data(8'd36, 30);
      rst = 1'b1;
      tick();
      post("rst_mid_m_valid", int'(bus.m_valid), 0);
      post("rst_mid_rd_en", int'(bus.fifo_rd_en), 0);
      post("rst_mid_m_last", int'(bus.m_last), 0);
      post("rst_mid_bursts", int'(bursts_done), 0);
      rst = 1'b0;
      repeat (5) tick();
      post("rst_idle_valid", int'(bus.m_valid), 0);

      post("all_bytes_delivered", mon_idx, int'(exp_data.size()));
      tick();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
